// File: rtl/gtclk_gated_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : gtclk_gated_reg_if
//  Description : Control and data bundle of the gated-clock register. It
//                carries the clock-gate controls, the load data, the
//                registered output and the observable gated clock.
//  Revision    : 1.0  initial release
// ============================================================================
interface gtclk_gated_reg_if #(
  parameter int WIDTH = 16
);
  logic             CKENB;
  logic             SCAN_TEST;
  logic             WBEN;
  logic [WIDTH-1:0] DI;
  logic [WIDTH-1:0] DI2;
  logic [WIDTH-1:0] DO;
  logic             GCLK;

  // Side that drives the controls and the load data
  modport master (
    output CKENB, SCAN_TEST, WBEN, DI, DI2,
    input  DO, GCLK
  );

  // Register side
  modport slave (
    input  CKENB, SCAN_TEST, WBEN, DI, DI2,
    output DO, GCLK
  );
endinterface
`default_nettype wire

// File: rtl/gtclk_gated_reg.sv
`default_nettype none
// ============================================================================
//  Module      : gtclk_gated_reg (with gate primitives and_not, gtclk_nor2,
//                gate_not)
//  Description : Parameterised register clocked by a DFT-aware gated clock.
//                GCLK = CLK | enb_l, so a stopped clock idles high and never
//                produces a rising edge. SCAN_TEST overrides the gate.
//  Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// and_not : Y = A & ~B   (scan override of the clock-gate disable)
// ----------------------------------------------------------------------------
module and_not (
  input  logic A,
  input  logic B,
  output logic Y
);
  assign Y = A & ~B;
endmodule

// ----------------------------------------------------------------------------
// gtclk_nor2 : Y = ~(A | B)   (clock gate cell)
// ----------------------------------------------------------------------------
module gtclk_nor2 (
  input  logic A,
  input  logic B,
  output logic Y
);
  assign Y = ~(A | B);
endmodule

// ----------------------------------------------------------------------------
// gate_not : Y = ~A   (restores clock polarity after the NOR gate)
// ----------------------------------------------------------------------------
module gate_not (
  input  logic A,
  output logic Y
);
  assign Y = ~A;
endmodule

// ----------------------------------------------------------------------------
// gtclk_gated_reg : top level
// ----------------------------------------------------------------------------
module gtclk_gated_reg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               DUAL_IN   = 1'b0,
  parameter bit               USE_LATCH = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  gtclk_gated_reg_if.slave    bus
);

  logic             enb_dft;    // gate disable after scan override
  logic             enb_l;      // gate disable as seen by the NOR gate
  logic             n1;         // NOR gate output (inverted gated clock)
  logic             gclk;       // gated register clock
  logic             load;       // load qualifier on an enabled edge
  logic [WIDTH-1:0] load_data;  // data selected for the next enabled edge
  logic [WIDTH-1:0] data_q;     // register contents

  // Scan mode forces the gate open: enb_dft = CKENB & ~SCAN_TEST
  and_not u_and_not (
    .A (bus.CKENB),
    .B (bus.SCAN_TEST),
    .Y (enb_dft)
  );

  if (USE_LATCH) begin : g_latch
    // Transparent while CLK is high; holds through the low phase so enable
    // changes while CLK is low cannot disturb GCLK
    always_latch begin
      if (CLK) enb_l <= enb_dft;
    end
  end else begin : g_no_latch
    // Caller guarantees CKENB only moves while CLK is high
    assign enb_l = enb_dft;
  end

  // GCLK = NOT(NOR(enb_l, CLK)) = CLK | enb_l; nothing else on the clock path
  gtclk_nor2 u_gtclk_nor2 (
    .A (enb_l),
    .B (CLK),
    .Y (n1)
  );

  gate_not u_gate_not (
    .A (n1),
    .Y (gclk)
  );

  if (DUAL_IN) begin : g_dual
    // Two-data form: every enabled edge loads, WBEN picks the source
    assign load      = 1'b1;
    assign load_data = bus.WBEN ? bus.DI : bus.DI2;
  end else begin : g_single
    // Single-data form: WBEN qualifies the load, otherwise hold
    assign load      = bus.WBEN;
    assign load_data = bus.DI;
  end

  // Data register on the gated clock with asynchronous reset
  always_ff @(posedge gclk or posedge RST) begin
    if (RST) begin
      data_q <= RESET_VAL;
    end else if (load) begin
      data_q <= load_data;
    end
  end

  assign bus.DO   = data_q;
  assign bus.GCLK = gclk;

endmodule
`default_nettype wire

// File: tb/tb_gtclk_gated_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gtclk_gated_reg
//  Description : Directed self-checking bench. Instance A is the 16-bit
//                single-input form, instance B the 8-bit dual-input form.
//                Inputs are driven 1 time unit after the rising clock edge
//                (inside the high phase) unless a test deliberately moves
//                CKENB during the low phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gtclk_gated_reg;

  logic CLK;
  logic RST;

  int checks = 0;
  int errors = 0;
  int edges_a = 0;
  int snap;

  gtclk_gated_reg_if #(.WIDTH(16)) bus_a ();
  gtclk_gated_reg_if #(.WIDTH(8))  bus_b ();

  gtclk_gated_reg #(
    .WIDTH     (16),
    .RESET_VAL (16'h0800),
    .DUAL_IN   (1'b0),
    .USE_LATCH (1'b1)
  ) dut_a (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_a.slave)
  );

  gtclk_gated_reg #(
    .WIDTH     (8),
    .RESET_VAL (8'h55),
    .DUAL_IN   (1'b1),
    .USE_LATCH (1'b1)
  ) dut_b (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_b.slave)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count rising edges of the gated clock of instance A
  always @(posedge bus_a.GCLK) edges_a <= edges_a + 1;

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 unit after the next rising CLK edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST             = 1'b1;
    bus_a.CKENB     = 1'b0;
    bus_a.SCAN_TEST = 1'b0;
    bus_a.WBEN      = 1'b0;
    bus_a.DI        = 16'h0000;
    bus_a.DI2       = 16'h0000;
    bus_b.CKENB     = 1'b0;
    bus_b.SCAN_TEST = 1'b0;
    bus_b.WBEN      = 1'b0;
    bus_b.DI        = 8'h00;
    bus_b.DI2       = 8'h00;

    // 1: reset value present before any clock edge
    #2;
    check("rst_a_no_clk", bus_a.DO, 32'h0800);
    check("rst_b_no_clk", bus_b.DO, 32'h55);
    tick();
    RST = 1'b0;
    #1;
    check("rst_release_a", bus_a.DO, 32'h0800);

    // 2: load, then hold with WBEN=0
    bus_a.WBEN = 1'b1;
    bus_a.DI   = 16'hA5A5;
    tick();
    check("load_a5a5", bus_a.DO, 32'hA5A5);
    bus_a.WBEN = 1'b0;
    bus_a.DI   = 16'h1234;
    tick();
    check("hold_wben0", bus_a.DO, 32'hA5A5);

    // 3: gated clock holds DO and GCLK stays high; scan override loads
    bus_a.CKENB = 1'b1;
    bus_a.WBEN  = 1'b1;
    bus_a.DI    = 16'hFFFF;
    @(negedge CLK);
    #1;
    snap = edges_a;
    for (int i = 0; i < 4; i++) begin
      check("gclk_low_gated", bus_a.GCLK, 32'h1);
      tick();
      check("gated_hold", bus_a.DO, 32'hA5A5);
      @(negedge CLK);
      #1;
    end
    check("gated_no_edges", edges_a, snap);
    tick();
    bus_a.SCAN_TEST = 1'b1;
    tick();
    check("scan_override", bus_a.DO, 32'hFFFF);
    bus_a.SCAN_TEST = 1'b0;
    bus_a.CKENB     = 1'b0;
    bus_a.WBEN      = 1'b0;

    // 4: dual-input form selects DI then DI2, holds when gated
    bus_b.WBEN = 1'b1;
    bus_b.DI   = 8'h3C;
    bus_b.DI2  = 8'h00;
    tick();
    check("dual_di", bus_b.DO, 32'h3C);
    bus_b.WBEN = 1'b0;
    bus_b.DI   = 8'h11;
    bus_b.DI2  = 8'hC3;
    tick();
    check("dual_di2", bus_b.DO, 32'hC3);
    bus_b.CKENB = 1'b1;
    bus_b.WBEN  = 1'b1;
    bus_b.DI    = 8'h99;
    tick();
    check("dual_gated_hold", bus_b.DO, 32'hC3);

    // 5: CKENB toggled in the low phase must not affect GCLK until the
    //    following high phase
    bus_a.WBEN = 1'b1;
    bus_a.DI   = 16'h0101;
    snap = edges_a;
    @(negedge CLK);
    #1;
    bus_a.CKENB = 1'b1;
    #2;
    check("low_toggle_gclk0", bus_a.GCLK, 32'h0);
    check("low_toggle_no_early", bus_a.DO, 32'hFFFF);
    tick();
    check("low_toggle_load", bus_a.DO, 32'h0101);
    bus_a.DI = 16'h0202;
    @(negedge CLK);
    #1;
    bus_a.CKENB = 1'b0;
    #2;
    check("low_toggle_gclk1", bus_a.GCLK, 32'h1);
    tick();
    check("low_toggle_skip", bus_a.DO, 32'h0101);
    tick();
    check("reenable_load", bus_a.DO, 32'h0202);
    check("edge_count", edges_a, snap + 2);

    // 6: reset asserted mid high phase with WBEN=1
    bus_a.WBEN = 1'b1;
    bus_a.DI   = 16'hBEEF;
    #1;
    RST = 1'b1;
    #1;
    check("rst_mid_a", bus_a.DO, 32'h0800);
    check("rst_mid_b", bus_b.DO, 32'h55);
    tick();
    tick();
    check("rst_held_a", bus_a.DO, 32'h0800);
    RST = 1'b0;
    #1;
    check("rst_released_a", bus_a.DO, 32'h0800);
    tick();
    check("first_load_after_rst", bus_a.DO, 32'hBEEF);
    check("b_gated_after_rst", bus_b.DO, 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
